game_controller: RTL

Top-level game sequencer for the jetpack runner. It owns `game_state`, which the player-motion block and the obstacle/render blocks consume:
- the player-motion block holds Barry at rest whenever the state is not PLAY;
- the controller starts a run on a start-button press, ends it on a collision, and enforces a post-death lockout so a held button cannot restart immediately;
- it keeps the distance score, the session high score and the difficulty level.

---
 rtl/game_pkg.sv | 29 ++
 rtl/score_counter.sv | 33 +++
 rtl/game_controller.sv | 105 ++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types for the jetpack runner: externally visible game state,
// the controller's internal FSM encoding and the difficulty ceiling.
package game_pkg;

    typedef enum logic [1:0] {
        GS_MENU = 2'b00,
        GS_PLAY = 2'b01,
        GS_OVER = 2'b10
    } game_state_t;

    typedef enum logic [1:0] {
        ST_MENU = 2'b00,
        ST_PLAY = 2'b01,
        ST_HOLD = 2'b10,
        ST_OVER = 2'b11
    } fsm_state_t;

    localparam int unsigned LEVEL_MAX = 3;

    // HOLD and OVER look identical to downstream blocks.
    function automatic game_state_t to_game_state(input fsm_state_t st);
        case (st)
            ST_PLAY:          return GS_PLAY;
            ST_HOLD, ST_OVER: return GS_OVER;
            default:          return GS_MENU;
        endcase
    endfunction

endpackage

// File: rtl/score_counter.sv
// Distance score: divides frame ticks by SCORE_DIV and counts points,
// saturating at all-ones.
module score_counter import game_pkg::*; #(
    parameter int unsigned SCORE_W   = 16,
    parameter int unsigned SCORE_DIV = 4
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               enable,
    input  logic               frame_tick,
    output logic [SCORE_W-1:0] score
);

    localparam int unsigned DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            div_cnt <= '0;
            score   <= '0;
        end else if (enable && frame_tick) begin
            if (div_cnt == DIV_W'(SCORE_DIV - 1)) begin
                div_cnt <= '0;
                if (score != '1)
                    score <= score + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_controller.sv
// Top-level game sequencer: start/collision FSM with post-death lockout,
// session high score and difficulty level.
module game_controller import game_pkg::*; #(
    parameter int unsigned SCORE_W        = 16,
    parameter int unsigned SCORE_DIV      = 4,
    parameter int unsigned LOCKOUT_FRAMES = 60,
    parameter int unsigned LEVEL_SHIFT    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               hit,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [1:0]         level,
    output logic               new_high,
    output logic               run_start
);

    localparam int unsigned LOCK_W = $clog2(LOCKOUT_FRAMES + 1);

    fsm_state_t         state;
    fsm_state_t         state_next;
    logic               start_q;
    logic               press;
    logic               launch;
    logic               score_clear;
    logic               score_en;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [SCORE_W-1:0] level_raw;

    assign press       = start & ~start_q;
    assign score_clear = reset | launch;
    // A hit on a scoring tick must not add a point.
    assign score_en    = (state == ST_PLAY) && !hit;

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            ST_MENU, ST_OVER: begin
                if (press) begin
                    state_next = ST_PLAY;
                    launch     = 1'b1;
                end
            end
            ST_PLAY: begin
                if (hit)
                    state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (frame_tick && lock_cnt == LOCK_W'(1))
                    state_next = ST_OVER;
            end
            default: state_next = ST_MENU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_MENU;
            game_state <= GS_MENU;
            start_q    <= 1'b0;
            lock_cnt   <= '0;
            high_score <= '0;
            new_high   <= 1'b0;
            run_start  <= 1'b0;
        end else begin
            state      <= state_next;
            game_state <= to_game_state(state_next);
            start_q    <= start;
            run_start  <= launch;
            if (launch)
                new_high <= 1'b0;
            if (state == ST_PLAY && hit) begin
                lock_cnt <= LOCK_W'(LOCKOUT_FRAMES);
                if (score > high_score) begin
                    high_score <= score;
                    new_high   <= 1'b1;
                end
            end else if (state == ST_HOLD && frame_tick) begin
                lock_cnt <= lock_cnt - 1'b1;
            end
        end
    end

    score_counter #(
        .SCORE_W   (SCORE_W),
        .SCORE_DIV (SCORE_DIV)
    ) u_score (
        .clk        (clk),
        .clear      (score_clear),
        .enable     (score_en),
        .frame_tick (frame_tick),
        .score      (score)
    );

    always_comb begin
        level_raw = score >> LEVEL_SHIFT;
        level     = (level_raw >= SCORE_W'(LEVEL_MAX)) ? 2'(LEVEL_MAX) : level_raw[1:0];
    end

endmodule
